// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared state encoding and default widths for the PC sequencer
package pc_seq_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_INSTR_W = 8;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE, HALT} state_t;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: priority mux/adder choosing jump target, taken-branch target or pc+1
module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_en,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] next_pc
);
  // jump beats a taken branch; everything else falls through to pc+1, wrapping modulo 2^ADDR_W
  always_comb
    next_pc = jump_en ? jump_target :
              (branch_en && branch_taken) ? pc + branch_offset :
              pc + ADDR_W'(1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute/update sequencer driving the PC write port
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_out,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_en,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_offset,
  input  logic               halt,
  output logic               pc_write,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               halted
);
  state_t state, state_nx;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0] next_pc_q, calc_pc;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_calc (
    .pc(pc_out),
    .jump_en(jump_en),
    .jump_target(jump_target),
    .branch_en(branch_en),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .next_pc(calc_pc)
  );

  // state, latched instruction and registered next PC; halting clears instr so HALT shows zeros
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      instr_q <= '0;
      next_pc_q <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && imem_ack) instr_q <= imem_data;
      if (state == EXEC && exec_done) begin
        if (halt) instr_q <= '0;
        else next_pc_q <= calc_pc;
      end
    end
  end

  // next-state and state-decoded outputs; acks and dones outside their states are ignored
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = FETCH;
      FETCH:   state_nx = imem_ack ? EXEC : FETCH;
      EXEC:    state_nx = exec_done ? (halt ? HALT : UPDATE) : EXEC;
      UPDATE:  state_nx = FETCH;
      default: state_nx = HALT;
    endcase
    imem_req = state == FETCH;
    imem_addr = imem_req ? pc_out : '0;
    instr_valid = state == EXEC;
    pc_write = state == UPDATE;
    halted = state == HALT;
    instr = instr_q;
    next_pc = next_pc_q;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer with a PC register model
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] pc_out, imem_addr, imem_data, instr, jump_target, branch_offset, next_pc;
  logic imem_req, imem_ack, instr_valid, exec_done, jump_en, branch_en, branch_taken, halt;
  logic pc_write, halted, pc_load;
  logic [7:0] pc_load_val;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_out(pc_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .jump_en(jump_en), .jump_target(jump_target), .branch_en(branch_en),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .halt(halt),
    .pc_write(pc_write), .next_pc(next_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // PC register: bench preload wins, otherwise loads next_pc at the end of UPDATE
  always @(posedge clk)
    if (pc_load) pc_out <= pc_load_val;
    else if (pc_write) pc_out <= next_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every pc_write must match the oldest expected next_pc
  always @(negedge clk)
    if (pc_write === 1'b1) begin
      if (exp_q.size() == 0) chk("pc_write_pending", 32'(exp_q.size()), 1);
      else chk("next_pc", next_pc, exp_q.pop_front());
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] v);
    pc_load = 1'b1;
    pc_load_val = v;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic run(input logic [7:0] addr, input logic [7:0] data, input logic jmp,
                     input logic [7:0] jt, input logic ben, input logic bt,
                     input logic [7:0] off, input logic hlt, input logic [7:0] exp_nx,
                     input int ack_dly, input int done_dly);
    chk("imem_req", imem_req, 1);
    chk("imem_addr", imem_addr, addr);
    repeat (ack_dly) begin
      tick();
      chk("req_held", imem_req, 1);
      chk("early_pc_write", pc_write, 0);
    end
    imem_ack = 1'b1;
    imem_data = data;
    tick();
    imem_ack = 1'b0;
    imem_data = 8'($urandom);
    chk("instr", instr, data);
    chk("instr_valid", instr_valid, 1);
    chk("req_dropped", imem_req, 0);
    repeat (done_dly) begin
      imem_ack = 1'b1;
      imem_data = ~data;
      tick();
      imem_ack = 1'b0;
      chk("valid_held", instr_valid, 1);
      chk("instr_stable", instr, data);
      chk("no_pc_write", pc_write, 0);
    end
    exec_done = 1'b1;
    jump_en = jmp;
    jump_target = jt;
    branch_en = ben;
    branch_taken = bt;
    branch_offset = off;
    halt = hlt;
    if (!hlt) exp_q.push_back(exp_nx);
    tick();
    {exec_done, jump_en, branch_en, branch_taken, halt} = '0;
    jump_target = '0;
    branch_offset = '0;
    if (hlt) begin
      chk("halted", halted, 1);
      chk("halt_no_write", pc_write, 0);
    end else begin
      chk("valid_off", instr_valid, 0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    pc_load = 1'b1;
    pc_load_val = 8'd0;
    {imem_ack, exec_done, jump_en, branch_en, branch_taken, halt} = '0;
    imem_data = '0;
    jump_target = '0;
    branch_offset = '0;
    tick();
    tick();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr", instr, 0);
    chk("rst_next_pc", next_pc, 0);
    reset = 1'b1;
    pc_load = 1'b0;
    tick();
    run(8'd0, 8'h11, 0, 8'h00, 0, 0, 8'h00, 0, 8'd1, 0, 0);
    run(8'd1, 8'h12, 0, 8'h00, 0, 0, 8'h00, 0, 8'd2, 0, 0);
    run(8'd2, 8'h13, 0, 8'h00, 0, 0, 8'h00, 0, 8'd3, 0, 0);
    run(8'd3, 8'h22, 1, 8'hF0, 1, 1, 8'h05, 0, 8'hF0, 0, 0);
    chk("jump_fetch_addr", imem_addr, 8'hF0);
    preload(8'd10);
    run(8'd10, 8'h33, 0, 8'h00, 1, 1, 8'hF6, 0, 8'd0, 0, 0);
    preload(8'd10);
    run(8'd10, 8'h34, 0, 8'h00, 1, 0, 8'hF6, 0, 8'd11, 0, 0);
    preload(8'd255);
    run(8'd255, 8'h44, 0, 8'h00, 0, 0, 8'h00, 0, 8'd0, 3, 1);
    run(8'd0, 8'h55, 0, 8'h00, 0, 0, 8'h00, 0, 8'd1, 0, 0);
    run(8'd1, 8'h66, 1, 8'h80, 0, 0, 8'h00, 1, 8'd0, 0, 0);
    imem_ack = 1'b1;
    exec_done = 1'b1;
    repeat (3) tick();
    {imem_ack, exec_done} = '0;
    chk("halt_stays", halted, 1);
    chk("halt_req", imem_req, 0);
    chk("halt_valid", instr_valid, 0);
    chk("halt_instr", instr, 0);
    chk("halt_next_pc", next_pc, 1);
    chk("halt_pc_out", pc_out, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("unhalt", halted, 0);
    tick();
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 1);
    imem_ack = 1'b1;
    imem_data = 8'h77;
    tick();
    imem_ack = 1'b0;
    chk("mid_exec_valid", instr_valid, 1);
    exec_done = 1'b1;
    reset = 1'b0;
    tick();
    exec_done = 1'b0;
    reset = 1'b1;
    chk("mrst_req", imem_req, 0);
    chk("mrst_valid", instr_valid, 0);
    chk("mrst_pc_write", pc_write, 0);
    chk("mrst_instr", instr, 0);
    chk("mrst_next_pc", next_pc, 0);
    tick();
    run(8'd1, 8'h88, 0, 8'h00, 0, 0, 8'h00, 0, 8'd2, 0, 0);
    chk("final_addr", imem_addr, 2);
    tick();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/sequencing controller that drives the program counter's write port. It reads the current PC, fetches the instruction at that address over a req/ack handshake, and holds it for the execute stage. When execute signals completion, it computes the next PC (increment, absolute jump, relative branch, or halt) and pulses `pc_write` with `next_pc` for one cycle. It sits between the PC register, instruction memory and the execute/control logic.

## Interface
Parameters:
- `ADDR_W`, 8: PC / instruction address width.
- `INSTR_W`, 8: instruction word width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge resets the block.
- `pc_out`  in  ADDR_W  current PC value from the PC register.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  ADDR_W  fetch address; equals `pc_out` while `imem_req==1`.
- `imem_ack`  in  1  memory has `imem_data` valid this cycle.
- `imem_data`  in  INSTR_W  fetched instruction.
- `instr`  out  INSTR_W  latched instruction for execute.
- `instr_valid`  out  1  `instr` valid; held until `exec_done`.
- `exec_done`  in  1  execute finished with current `instr`; control inputs sampled this cycle.
- `jump_en`  in  1  absolute jump requested.
- `jump_target`  in  ADDR_W  absolute jump address.
- `branch_en`  in  1  conditional branch instruction.
- `branch_taken`  in  1  branch condition true.
- `branch_offset`  in  ADDR_W  two's-complement offset relative to `pc_out`.
- `halt`  in  1  halt requested.
- `pc_write`  out  1  PC write enable, one-cycle pulse.
- `next_pc`  out  ADDR_W  value to load into PC.
- `halted`  out  1  sequencer stopped.

## Operation
- States: IDLE, FETCH, EXEC, UPDATE, HALT.
- Reset: state=IDLE; `imem_req`, `instr_valid`, `pc_write`, `halted` = 0; `instr`, `next_pc`, `imem_addr` = 0.
- IDLE: one cycle, -> FETCH.
- FETCH: `imem_req=1`, `imem_addr=pc_out`. On `imem_ack`: latch `imem_data` into `instr`, -> EXEC. Otherwise remain.
- EXEC: `instr_valid=1`. On `exec_done`: register `next_pc` per priority; -> HALT if `halt`, else -> UPDATE.
- Next-PC priority: `halt` (no write) > `jump_en` (`jump_target`) > `branch_en && branch_taken` (`pc_out + branch_offset`) > `pc_out + 1`. `branch_en` with `!branch_taken` gives `pc_out + 1`.
- UPDATE: `pc_write=1` for exactly this cycle, then -> FETCH.
- HALT: `halted=1`, all other outputs 0, `next_pc` holds its last value; exits only on reset.
- Arithmetic: all ADDR_W-bit, modulo 2^ADDR_W; 255+1 -> 0; 10 + 0xF6 -> 0.
- `imem_ack` outside FETCH and `exec_done` outside EXEC are ignored.

## Timing
- `imem_req` rises the cycle after IDLE, i.e. the second cycle after reset release.
- Minimum instruction period 3 cycles (FETCH with ack, EXEC with done, UPDATE); each cycle of ack or done delay adds one.
- `instr` updates on the FETCH->EXEC edge; `instr_valid` is 1 from the next cycle until the EXEC->UPDATE edge.
- `pc_write`/`next_pc` registered; the PC register loads at the end of UPDATE, so FETCH sees the new `pc_out` in its first cycle.
- Reset mid-operation (any state): all outputs at reset values the following cycle; an in-flight `imem_ack` or `exec_done` in the reset cycle is discarded.

## Structure
- Package `pc_seq_pkg`: state enum (IDLE, FETCH, EXEC, UPDATE, HALT), `ADDR_W`/`INSTR_W` defaults.
- Sub-module `pc_next_calc`: combinational priority mux/adder producing next PC from `pc_out` and control inputs; the FSM registers its output.
- Bench instantiates `pc_sequencer` with the PC register.

## Test plan
- Reset then sequential run, ack and done same cycle: PC 0 -> 1 -> 2; `pc_write` pulses every 3rd cycle; `imem_addr` 0, 1, 2.
- `jump_en=1`, `jump_target=8'hF0` with `branch_en=branch_taken=1` simultaneously: `next_pc=8'hF0` (jump wins).
- Branch at PC=10, offset 8'hF6, taken -> `next_pc=0`; same with `branch_taken=0` -> 11.
- Wrap: PC=255, plain instruction -> `next_pc=0`, `imem_addr=0` next fetch.
- Ack delayed 3 cycles: `imem_req` held 4 cycles, `instr` equals data at ack, `pc_write` not asserted before `exec_done`.
- `halt` with `exec_done`: no `pc_write`, `halted=1`, stays halted; reset low mid-EXEC then released -> IDLE, fetch restarts at current `pc_out`.
